axi_raddr_arbiter: RTL and testbench
====================================

AXI_RADDR_ARBITER -- requirements
Module: axi_raddr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 2, number of upstream read requesters (legal range 2..8).
REQ-002 SHALL have parameter C_AXI_ADDR_WIDTH, default 8, read address width.
REQ-003 SHALL have parameter C_AXI_DATA_WIDTH, default 32, read data width.
REQ-004 SHALL have parameter maxwait, default 5, AR-ready wait limit in cycles (legal range 1..255).
REQ-005 SHALL have port AXI_ACLK, input, 1 bit: the single clock; all logic samples on its rising edge.
REQ-006 SHALL have port AXI_ARESETN, input, 1 bit: reset, asynchronous assertion, active-low.
REQ-007 SHALL have port S_ARADDR, input, NUM_REQ*C_AXI_ADDR_WIDTH bits: requester addresses; requester i occupies slice [i*AW +: AW].
REQ-008 SHALL have port S_ARVALID, input, NUM_REQ bits: per-requester address valid.
REQ-009 SHALL have port S_ARREADY, output, NUM_REQ bits: per-requester address accept.
REQ-010 SHALL have port S_RDATA, output, C_AXI_DATA_WIDTH bits: read data, broadcast to all requesters.
REQ-011 SHALL have port S_RRESP, output, 2 bits: read response, broadcast to all requesters.
REQ-012 SHALL have port S_RVALID, output, NUM_REQ bits: per-requester read valid.
REQ-013 SHALL have port S_RREADY, input, NUM_REQ bits: per-requester read ready.
REQ-014 SHALL have port M_ARADDR, output, C_AXI_ADDR_WIDTH bits: shared slave read address.
REQ-015 SHALL have port M_ARVALID, output, 1 bit: shared slave read address valid.
REQ-016 SHALL have port M_ARREADY, input, 1 bit: shared slave read address ready.
REQ-017 SHALL have port M_RDATA, input, C_AXI_DATA_WIDTH bits: shared slave read data.
REQ-018 SHALL have port M_RRESP, input, 2 bits: shared slave read response.
REQ-019 SHALL have port M_RVALID, input, 1 bit: shared slave read valid.
REQ-020 SHALL have port M_RREADY, output, 1 bit: shared slave read ready.
REQ-021 SHALL have port GRANT, output, NUM_REQ bits: one-hot owner of the current transaction, all-zero when IDLE.
REQ-022 SHALL have port AR_TIMEOUT, output, 1 bit: sticky flag set when the AR wait limit is exceeded.

Function
REQ-023 SHALL implement a three-state FSM: IDLE, ADDR, DATA; exactly one read transaction outstanding at a time.
REQ-024 IDLE: if any S_ARVALID bit is set, SHALL select winner g by round-robin, searching from (last_grant+1) mod NUM_REQ upward.
REQ-025 IDLE with a winner: SHALL drive S_ARREADY[g]=1 combinationally that cycle, register S_ARADDR slice g into the address register, register one-hot GRANT, and go to ADDR.
REQ-026 S_ARREADY SHALL be 0 on all bits in ADDR and DATA, and on all non-winner bits in IDLE.
REQ-027 ADDR: SHALL hold M_ARVALID=1 with M_ARADDR equal to the latched address, unchanged until M_ARREADY=1; on M_ARVALID&M_ARREADY SHALL go to DATA.
REQ-028 M_ARVALID SHALL be 0 in IDLE and DATA; M_ARVALID SHALL never deassert in ADDR without M_ARREADY.
REQ-029 DATA: S_RVALID[g]=M_RVALID and M_RREADY=S_RREADY[g], combinational; S_RDATA=M_RDATA and S_RRESP=M_RRESP always.
REQ-030 DATA: S_RVALID for non-granted requesters SHALL be 0; M_RREADY SHALL be 0 outside DATA.
REQ-031 On M_RVALID&M_RREADY in DATA: SHALL set last_grant=g, clear GRANT, and go to IDLE; the next arbitration occurs no earlier than the following cycle.
REQ-032 A wait counter SHALL clear on ADDR entry and increment each ADDR cycle with M_ARREADY=0, saturating at 255.
REQ-033 When the wait counter reaches maxwait, AR_TIMEOUT SHALL set on the next edge and stay set until reset; M_ARVALID stays asserted.
REQ-034 A requester dropping S_ARVALID after acceptance SHALL NOT affect the transaction in progress.
REQ-035 With a single requester continuously valid, that requester SHALL be re-granted every transaction (no idle bubbles beyond REQ-031).

Reset
REQ-036 While AXI_ARESETN=0: FSM=IDLE, GRANT=0, S_ARREADY=0, S_RVALID=0, M_ARVALID=0, M_RREADY=0, M_ARADDR=0, AR_TIMEOUT=0, wait counter=0.
REQ-037 Reset SHALL set last_grant=NUM_REQ-1 so requester 0 has priority first.
REQ-038 Reset asserted mid-ADDR or mid-DATA SHALL abort immediately to IDLE with all outputs at REQ-036 values; no recovery of the aborted transaction.

Verification
REQ-039 After reset, S_ARVALID=2'b11, addrs 0x10/0x20 -> S_ARREADY=2'b01, M_ARADDR=0x10, GRANT=2'b01; next transaction grants req1 with M_ARADDR=0x20.
REQ-040 In ADDR, M_ARREADY held 0 for 3 cycles -> M_ARVALID and M_ARADDR stable all 3 cycles, AR_TIMEOUT stays 0; handshake on 4th cycle -> DATA.
REQ-041 M_ARREADY held 0 for 7 cycles with maxwait=5 -> AR_TIMEOUT=1 from the cycle after count reaches 5 and remains 1 after completion.
REQ-042 In DATA with g=1, M_RVALID=1, M_RDATA=0xDEADBEEF, S_RREADY=2'b01 -> S_RVALID=2'b10, M_RREADY=0, FSM stays DATA; S_RREADY=2'b10 -> completes, IDLE next cycle.
REQ-043 AXI_ARESETN pulsed low mid-DATA -> all outputs 0 asynchronously; after release with S_ARVALID=2'b11, requester 0 is granted.
REQ-044 Requester 0 only, valid continuously for 4 transactions -> 4 grants to req0, each IDLE->ADDR->DATA with one IDLE cycle between.

Source files
------------

// File: rtl/axi_raddr_arbiter.sv
// Round-robin arbiter that lets several AXI read masters share one read slave.
// Only one read transaction is in flight at a time: the winner's address is
// latched, presented to the slave until accepted, and the single read beat is
// routed back to the owner before the next arbitration takes place.
module axi_raddr_arbiter #(
  parameter int NUM_REQ          = 2,
  parameter int C_AXI_ADDR_WIDTH = 8,
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int maxwait          = 5
) (
  input  logic                                AXI_ACLK,
  input  logic                                AXI_ARESETN,
  input  logic [NUM_REQ*C_AXI_ADDR_WIDTH-1:0] S_ARADDR,
  input  logic [NUM_REQ-1:0]                  S_ARVALID,
  output logic [NUM_REQ-1:0]                  S_ARREADY,
  output logic [C_AXI_DATA_WIDTH-1:0]         S_RDATA,
  output logic [1:0]                          S_RRESP,
  output logic [NUM_REQ-1:0]                  S_RVALID,
  input  logic [NUM_REQ-1:0]                  S_RREADY,
  output logic [C_AXI_ADDR_WIDTH-1:0]         M_ARADDR,
  output logic                                M_ARVALID,
  input  logic                                M_ARREADY,
  input  logic [C_AXI_DATA_WIDTH-1:0]         M_RDATA,
  input  logic [1:0]                          M_RRESP,
  input  logic                                M_RVALID,
  output logic                                M_RREADY,
  output logic [NUM_REQ-1:0]                  GRANT,
  output logic                                AR_TIMEOUT
);

  localparam int IDXW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t                      state_q;
  logic [NUM_REQ-1:0]          grant_q;
  logic [IDXW-1:0]             grantIdx_q;
  logic [IDXW-1:0]             lastGrant_q;
  logic [C_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [7:0]                  waitCnt_q;
  logic [7:0]                  waitCnt_d;
  logic                        timeout_q;

  logic                        winnerFound;
  logic [IDXW-1:0]             winnerIdx;
  logic [NUM_REQ-1:0]          winnerOneHot;
  logic [C_AXI_ADDR_WIDTH-1:0] winnerAddr;
  logic                        ownerReady;
  logic                        rHandshake;

  // Round-robin search: priority starts just past the last owner and wraps
  always_comb begin
    winnerFound  = 1'b0;
    winnerIdx    = '0;
    winnerOneHot = '0;
    winnerAddr   = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!winnerFound && S_ARVALID[i] &&
            (i == ((int'(lastGrant_q) + 1 + off) % NUM_REQ))) begin
          winnerFound     = 1'b1;
          winnerIdx       = IDXW'(i);
          winnerOneHot[i] = 1'b1;
          winnerAddr      = S_ARADDR[i*C_AXI_ADDR_WIDTH +: C_AXI_ADDR_WIDTH];
        end
      end
    end
  end

  // AR wait counter: cleared when a new address is taken, counts stalled ADDR cycles
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_q == IDLE && winnerFound) begin
      waitCnt_d = '0;
    end else if (state_q == ADDR && !M_ARREADY && waitCnt_q != 8'hFF) begin
      waitCnt_d = waitCnt_q + 8'd1;
    end
  end

  assign ownerReady = |(S_RREADY & grant_q);
  assign rHandshake = (state_q == DATA) && M_RVALID && ownerReady;

  // Main transaction FSM with the latched address, owner and sticky timeout
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      grantIdx_q  <= '0;
      lastGrant_q <= IDXW'(NUM_REQ - 1);
      addr_q      <= '0;
      waitCnt_q   <= '0;
      timeout_q   <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      if (waitCnt_q >= 8'(maxwait)) begin
        timeout_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (winnerFound) begin
            state_q    <= ADDR;
            grant_q    <= winnerOneHot;
            grantIdx_q <= winnerIdx;
            addr_q     <= winnerAddr;
          end
        end
        ADDR: begin
          if (M_ARREADY) begin
            state_q <= DATA;
          end
        end
        DATA: begin
          if (rHandshake) begin
            state_q     <= IDLE;
            lastGrant_q <= grantIdx_q;
            grant_q     <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  // The accept pulse is combinational, so it is also masked while reset is held
  assign S_ARREADY  = (AXI_ARESETN && state_q == IDLE) ? winnerOneHot : '0;
  assign M_ARVALID  = (state_q == ADDR);
  assign M_ARADDR   = addr_q;
  assign M_RREADY   = (state_q == DATA) && ownerReady;
  assign S_RVALID   = (state_q == DATA) ? (grant_q & {NUM_REQ{M_RVALID}}) : '0;
  assign S_RDATA    = M_RDATA;
  assign S_RRESP    = M_RRESP;
  assign GRANT      = grant_q;
  assign AR_TIMEOUT = timeout_q;

endmodule

// File: tb/tb_axi_raddr_arbiter.sv
// Self-checking bench for axi_raddr_arbiter with two requesters.
// Expected grants/addresses come from a round-robin model pushed into a
// scoreboard when requests are driven and popped when the slave sees the AR.
module tb_axi_raddr_arbiter;

  localparam int NREQ    = 2;
  localparam int AW      = 8;
  localparam int DW      = 32;
  localparam int MAXWAIT = 5;

  logic             clk = 1'b0;
  logic             rstN;
  logic [NREQ*AW-1:0] sArAddr;
  logic [NREQ-1:0]  sArValid;
  logic [NREQ-1:0]  sArReady;
  logic [DW-1:0]    sRData;
  logic [1:0]       sRResp;
  logic [NREQ-1:0]  sRValid;
  logic [NREQ-1:0]  sRReady;
  logic [AW-1:0]    mArAddr;
  logic             mArValid;
  logic             mArReady;
  logic [DW-1:0]    mRData;
  logic [1:0]       mRResp;
  logic             mRValid;
  logic             mRReady;
  logic [NREQ-1:0]  grant;
  logic             arTimeout;

  typedef struct {
    logic [NREQ-1:0] gnt;
    logic [AW-1:0]   addr;
  } expTxn_t;

  expTxn_t sbq[$];
  int      modelLast;
  int      checks = 0;
  int      errors = 0;

  // Free-running clock
  always #5 clk = ~clk;

  axi_raddr_arbiter #(
    .NUM_REQ(NREQ),
    .C_AXI_ADDR_WIDTH(AW),
    .C_AXI_DATA_WIDTH(DW),
    .maxwait(MAXWAIT)
  ) dut (
    .AXI_ACLK(clk),
    .AXI_ARESETN(rstN),
    .S_ARADDR(sArAddr),
    .S_ARVALID(sArValid),
    .S_ARREADY(sArReady),
    .S_RDATA(sRData),
    .S_RRESP(sRResp),
    .S_RVALID(sRValid),
    .S_RREADY(sRReady),
    .M_ARADDR(mArAddr),
    .M_ARVALID(mArValid),
    .M_ARREADY(mArReady),
    .M_RDATA(mRData),
    .M_RRESP(mRResp),
    .M_RVALID(mRValid),
    .M_RREADY(mRReady),
    .GRANT(grant),
    .AR_TIMEOUT(arTimeout)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference round-robin pick: search from last+1 upward with wrap
  function automatic int rrPick(input logic [NREQ-1:0] v, input int last);
    for (int off = 1; off <= NREQ; off++) begin
      int idx;
      idx = (last + off) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Drive requests while the arbiter is idle and record the expected winner
  task automatic applyStimulus(input logic [NREQ-1:0] v, input logic [AW-1:0] a0,
                               input logic [AW-1:0] a1);
    expTxn_t e;
    int w;
    sArValid = v;
    sArAddr  = {a1, a0};
    if (v != '0) begin
      w = rrPick(v, modelLast);
      if (w >= 0) begin
        e.gnt  = NREQ'(1) << w;
        e.addr = (w == 0) ? a0 : a1;
        sbq.push_back(e);
        modelLast = w;
      end
    end
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    sArValid = 2'b11; sArAddr = 16'h2010;
    sRReady = 2'b11; mRValid = 1'b1; mArReady = 1'b0;
    mRData = '0; mRResp = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL reset_grant got %b expected 00", grant); end
    checks++; if (sArReady !== 2'b00) begin errors++; $display("[TB] FAIL reset_arready got %b expected 00", sArReady); end
    checks++; if (sRValid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid got %b expected 00", sRValid); end
    checks++; if (mArValid !== 1'b0) begin errors++; $display("[TB] FAIL reset_marvalid got %b expected 0", mArValid); end
    checks++; if (mRReady !== 1'b0) begin errors++; $display("[TB] FAIL reset_mrready got %b expected 0", mRReady); end
    checks++; if (mArAddr !== 8'h00) begin errors++; $display("[TB] FAIL reset_maraddr got %h expected 00", mArAddr); end
    checks++; if (arTimeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout got %b expected 0", arTimeout); end
    sArValid = 2'b00; sRReady = 2'b00; mRValid = 1'b0;
    modelLast = NREQ - 1;
    sbq.delete();
    rstN = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    expTxn_t e;
    for (int n = 0; n < 2; n++) begin
      applyStimulus(2'b11, 8'h10, 8'h20);
      #1;
      checks++; if (sArReady !== sbq[0].gnt) begin errors++; $display("[TB] FAIL rr_arready%0d got %b expected %b", n, sArReady, sbq[0].gnt); end
      tick();
      sArValid = 2'b00; mArReady = 1'b1;
      #1;
      e = sbq.pop_front();
      checks++; if (grant !== e.gnt) begin errors++; $display("[TB] FAIL rr_grant%0d got %b expected %b", n, grant, e.gnt); end
      checks++; if (mArAddr !== e.addr) begin errors++; $display("[TB] FAIL rr_addr%0d got %h expected %h", n, mArAddr, e.addr); end
      checks++; if (mArValid !== 1'b1) begin errors++; $display("[TB] FAIL rr_arvalid%0d got %b expected 1", n, mArValid); end
      tick();
      mArReady = 1'b0; mRValid = 1'b1; mRData = 32'h1111_0000; sRReady = e.gnt;
      #1;
      checks++; if (sRValid !== e.gnt) begin errors++; $display("[TB] FAIL rr_rvalid%0d got %b expected %b", n, sRValid, e.gnt); end
      tick();
      mRValid = 1'b0; sRReady = 2'b00;
    end
  endtask

  task automatic test_ar_wait();
    expTxn_t e;
    applyStimulus(2'b01, 8'h33, 8'h00);
    tick();
    sArValid = 2'b00; mArReady = 1'b0;
    #1;
    e = sbq.pop_front();
    checks++; if (grant !== e.gnt) begin errors++; $display("[TB] FAIL wait_grant got %b expected %b", grant, e.gnt); end
    for (int k = 1; k <= 3; k++) begin
      checks++; if (mArValid !== 1'b1) begin errors++; $display("[TB] FAIL wait_arvalid_c%0d got %b expected 1", k, mArValid); end
      checks++; if (mArAddr !== e.addr) begin errors++; $display("[TB] FAIL wait_addr_c%0d got %h expected %h", k, mArAddr, e.addr); end
      checks++; if (arTimeout !== 1'b0) begin errors++; $display("[TB] FAIL wait_timeout_c%0d got %b expected 0", k, arTimeout); end
      tick();
    end
    mArReady = 1'b1;
    #1;
    checks++; if (mArValid !== 1'b1) begin errors++; $display("[TB] FAIL wait_arvalid_hs got %b expected 1", mArValid); end
    tick();
    mArReady = 1'b0;
    #1;
    checks++; if (mArValid !== 1'b0) begin errors++; $display("[TB] FAIL wait_arvalid_data got %b expected 0", mArValid); end
    mRValid = 1'b1; sRReady = 2'b01;
    tick();
    mRValid = 1'b0; sRReady = 2'b00;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL wait_idle_grant got %b expected 00", grant); end
  endtask

  task automatic test_data_phase();
    expTxn_t e;
    mRData = 32'hCAFE_F00D; mRResp = 2'b01;
    applyStimulus(2'b10, 8'h00, 8'h44);
    #1;
    checks++; if (sRData !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL data_idle_rdata got %h expected cafef00d", sRData); end
    checks++; if (sArReady !== sbq[0].gnt) begin errors++; $display("[TB] FAIL data_arready got %b expected %b", sArReady, sbq[0].gnt); end
    tick();
    sArValid = 2'b00; mArReady = 1'b1;
    #1;
    e = sbq.pop_front();
    checks++; if (grant !== e.gnt) begin errors++; $display("[TB] FAIL data_grant got %b expected %b", grant, e.gnt); end
    tick();
    mArReady = 1'b0;
    mRValid = 1'b1; mRData = 32'hDEAD_BEEF; mRResp = 2'b10; sRReady = 2'b01;
    #1;
    checks++; if (sRValid !== 2'b10) begin errors++; $display("[TB] FAIL data_rvalid got %b expected 10", sRValid); end
    checks++; if (mRReady !== 1'b0) begin errors++; $display("[TB] FAIL data_mrready_other got %b expected 0", mRReady); end
    checks++; if (sRData !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL data_rdata got %h expected deadbeef", sRData); end
    checks++; if (sRResp !== 2'b10) begin errors++; $display("[TB] FAIL data_rresp got %b expected 10", sRResp); end
    tick();
    checks++; if (sRValid !== 2'b10) begin errors++; $display("[TB] FAIL data_hold_rvalid got %b expected 10", sRValid); end
    checks++; if (grant !== e.gnt) begin errors++; $display("[TB] FAIL data_hold_grant got %b expected %b", grant, e.gnt); end
    sRReady = 2'b10;
    #1;
    checks++; if (mRReady !== 1'b1) begin errors++; $display("[TB] FAIL data_mrready_owner got %b expected 1", mRReady); end
    tick();
    mRValid = 1'b0; sRReady = 2'b00;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL data_done_grant got %b expected 00", grant); end
    checks++; if (sRValid !== 2'b00) begin errors++; $display("[TB] FAIL data_done_rvalid got %b expected 00", sRValid); end
  endtask

  task automatic test_timeout();
    expTxn_t e;
    logic expTo;
    applyStimulus(2'b01, 8'h55, 8'h00);
    tick();
    sArValid = 2'b00; mArReady = 1'b0;
    #1;
    e = sbq.pop_front();
    checks++; if (grant !== e.gnt) begin errors++; $display("[TB] FAIL to_grant got %b expected %b", grant, e.gnt); end
    for (int k = 1; k <= 7; k++) begin
      expTo = (k >= MAXWAIT + 2);
      checks++; if (arTimeout !== expTo) begin errors++; $display("[TB] FAIL to_flag_c%0d got %b expected %b", k, arTimeout, expTo); end
      checks++; if (mArValid !== 1'b1 || mArAddr !== e.addr) begin errors++; $display("[TB] FAIL to_ar_c%0d got %b/%h expected 1/%h", k, mArValid, mArAddr, e.addr); end
      tick();
    end
    mArReady = 1'b1;
    tick();
    mArReady = 1'b0; mRValid = 1'b1; sRReady = 2'b01;
    tick();
    mRValid = 1'b0; sRReady = 2'b00;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL to_done_grant got %b expected 00", grant); end
    checks++; if (arTimeout !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky got %b expected 1", arTimeout); end
  endtask

  task automatic test_reset_mid_data();
    expTxn_t e;
    applyStimulus(2'b01, 8'h66, 8'h00);
    tick();
    sArValid = 2'b00; mArReady = 1'b1;
    #1;
    e = sbq.pop_front();
    checks++; if (grant !== e.gnt) begin errors++; $display("[TB] FAIL rst_grant got %b expected %b", grant, e.gnt); end
    tick();
    mArReady = 1'b0; mRValid = 1'b1; sRReady = 2'b00;
    #1;
    checks++; if (sRValid !== e.gnt) begin errors++; $display("[TB] FAIL rst_pre_rvalid got %b expected %b", sRValid, e.gnt); end
    rstN = 1'b0; sArValid = 2'b11; sRReady = 2'b11;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_grant got %b expected 00", grant); end
    checks++; if (sArReady !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_arready got %b expected 00", sArReady); end
    checks++; if (sRValid !== 2'b00) begin errors++; $display("[TB] FAIL rst_mid_rvalid got %b expected 00", sRValid); end
    checks++; if (mArValid !== 1'b0 || mRReady !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_mhs got %b/%b expected 0/0", mArValid, mRReady); end
    checks++; if (mArAddr !== 8'h00) begin errors++; $display("[TB] FAIL rst_mid_addr got %h expected 00", mArAddr); end
    checks++; if (arTimeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_timeout got %b expected 0", arTimeout); end
    mRValid = 1'b0; sRReady = 2'b00;
    modelLast = NREQ - 1;
    tick();
    rstN = 1'b1;
    applyStimulus(2'b11, 8'h70, 8'h71);
    #1;
    checks++; if (sArReady !== sbq[0].gnt) begin errors++; $display("[TB] FAIL rst_after_arready got %b expected %b", sArReady, sbq[0].gnt); end
    tick();
    sArValid = 2'b00; mArReady = 1'b1;
    #1;
    e = sbq.pop_front();
    checks++; if (grant !== e.gnt || mArAddr !== e.addr) begin errors++; $display("[TB] FAIL rst_after_grant got %b/%h expected %b/%h", grant, mArAddr, e.gnt, e.addr); end
    tick();
    mArReady = 1'b0; mRValid = 1'b1; sRReady = 2'b01;
    tick();
    mRValid = 1'b0; sRReady = 2'b00;
  endtask

  task automatic test_back_to_back();
    expTxn_t e;
    sRReady = 2'b01;
    for (int n = 0; n < 4; n++) begin
      applyStimulus(2'b01, 8'(8'h80 + n), 8'h00);
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL b2b_idle_grant%0d got %b expected 00", n, grant); end
      checks++; if (sArReady !== sbq[0].gnt) begin errors++; $display("[TB] FAIL b2b_arready%0d got %b expected %b", n, sArReady, sbq[0].gnt); end
      tick();
      mArReady = 1'b1;
      #1;
      e = sbq.pop_front();
      checks++; if (grant !== e.gnt || mArAddr !== e.addr) begin errors++; $display("[TB] FAIL b2b_grant%0d got %b/%h expected %b/%h", n, grant, mArAddr, e.gnt, e.addr); end
      checks++; if (sArReady !== 2'b00) begin errors++; $display("[TB] FAIL b2b_addr_arready%0d got %b expected 00", n, sArReady); end
      tick();
      mArReady = 1'b0; mRValid = 1'b1; mRData = DW'(n);
      #1;
      checks++; if (mRReady !== 1'b1) begin errors++; $display("[TB] FAIL b2b_mrready%0d got %b expected 1", n, mRReady); end
      tick();
      mRValid = 1'b0;
    end
    sArValid = 2'b00; sRReady = 2'b00;
    tick();
    checks++; if (grant !== 2'b00) begin errors++; $display("[TB] FAIL b2b_final_grant got %b expected 00", grant); end
    checks++; if (sbq.size() != 0) begin errors++; $display("[TB] FAIL sb_leftover got %0d expected 0", sbq.size()); end
  endtask

  // Test sequence
  initial begin
    rstN = 1'b0;
    sArValid = '0; sArAddr = '0; sRReady = '0;
    mArReady = 1'b0; mRValid = 1'b0; mRData = '0; mRResp = 2'b00;
    modelLast = NREQ - 1;
    test_reset();
    test_round_robin();
    test_ar_wait();
    test_data_phase();
    test_timeout();
    test_reset_mid_data();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got no completion expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
